// File: rtl/ballot_session_ctrl.sv
// One-voter-one-vote ballot sequencer with lockout, timeout and a results-mode winner scan.
// Define VOTE_AUDIT_EN to enable the saturating granted-vote counter on total_votes.
module ballot_session_ctrl #(
    parameter int NUM_CAND    = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYC    = 10,
    parameter int ARM_TIMEOUT = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        officer_arm,
    input  logic [NUM_CAND-1:0]         vote_req,
    input  logic [NUM_CAND*CNT_W-1:0]   cand_cnt,
    output logic                        inc_en,
    output logic [NUM_CAND-1:0]         inc_sel,
    output logic                        ballot_ready,
    output logic                        busy_led,
    output logic                        reject,
    output logic                        timeout,
    output logic                        sat_flag,
    output logic                        result_vld,
    output logic [$clog2(NUM_CAND)-1:0] winner_idx,
    output logic [CNT_W-1:0]            winner_cnt,
    output logic                        tie,
    output logic [15:0]                 total_votes
);

    localparam int IW = $clog2(NUM_CAND);
    localparam int TW = $clog2(ARM_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_CYC + 1);
    localparam logic [TW-1:0]    ARM_LAST  = TW'(ARM_TIMEOUT - 1);
    localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYC - 1);
    localparam logic [IW-1:0]    SCAN_LAST = IW'(NUM_CAND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_GRANT,
        ST_LOCKOUT,
        ST_SCAN,
        ST_RESULT
    } state_t;

    state_t            state;
    logic [TW-1:0]     arm_timer;
    logic [LW-1:0]     lock_cnt;
    logic [IW-1:0]     scan_idx;
    logic [CNT_W-1:0]  best_cnt;
    logic [IW-1:0]     best_idx;
    logic              best_tie;

    logic              req_any;
    logic              req_one;
    logic [CNT_W-1:0]  sel_cnt;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W-1:0]  nb_cnt;
    logic [IW-1:0]     nb_idx;
    logic              nb_tie;

    assign req_any = |vote_req;
    assign req_one = req_any && ((vote_req & (vote_req - NUM_CAND'(1))) == '0);

    always_comb begin
        sel_cnt = '0;
        cur_cnt = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_req[i]) sel_cnt = sel_cnt | cand_cnt[i*CNT_W +: CNT_W];
            if (scan_idx == IW'(i)) cur_cnt = cand_cnt[i*CNT_W +: CNT_W];
        end
    end

    // Running best including the candidate under scan; index 0 seeds the search.
    always_comb begin
        nb_cnt = best_cnt;
        nb_idx = best_idx;
        nb_tie = best_tie;
        if (scan_idx == '0) begin
            nb_cnt = cur_cnt;
            nb_idx = '0;
            nb_tie = 1'b0;
        end else if (cur_cnt > best_cnt) begin
            nb_cnt = cur_cnt;
            nb_idx = scan_idx;
            nb_tie = 1'b0;
        end else if (cur_cnt == best_cnt) begin
            nb_tie = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            arm_timer    <= '0;
            lock_cnt     <= '0;
            scan_idx     <= '0;
            best_cnt     <= '0;
            best_idx     <= '0;
            best_tie     <= 1'b0;
            inc_en       <= 1'b0;
            inc_sel      <= '0;
            ballot_ready <= 1'b0;
            busy_led     <= 1'b0;
            reject       <= 1'b0;
            timeout      <= 1'b0;
            sat_flag     <= 1'b0;
            result_vld   <= 1'b0;
            winner_idx   <= '0;
            winner_cnt   <= '0;
            tie          <= 1'b0;
        end else begin
            inc_en  <= 1'b0;
            reject  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_any) reject <= 1'b1;
                    if (mode) begin
                        state    <= ST_SCAN;
                        scan_idx <= '0;
                    end else if (officer_arm) begin
                        state        <= ST_ARMED;
                        ballot_ready <= 1'b1;
                        arm_timer    <= '0;
                    end
                end
                ST_ARMED: begin
                    // A request always beats expiry; a multi-bit request keeps the ballot open.
                    if (req_one) begin
                        state        <= ST_GRANT;
                        ballot_ready <= 1'b0;
                        busy_led     <= 1'b1;
                        inc_sel      <= vote_req;
                        if (sel_cnt == CNT_MAX) begin
                            reject   <= 1'b1;
                            sat_flag <= 1'b1;
                        end else begin
                            inc_en <= 1'b1;
                        end
                    end else if (req_any) begin
                        reject <= 1'b1;
                        if (arm_timer != ARM_LAST) arm_timer <= arm_timer + TW'(1);
                    end else if (arm_timer == ARM_LAST) begin
                        state        <= ST_IDLE;
                        ballot_ready <= 1'b0;
                        timeout      <= 1'b1;
                    end else begin
                        arm_timer <= arm_timer + TW'(1);
                    end
                end
                ST_GRANT: begin
                    state    <= ST_LOCKOUT;
                    lock_cnt <= '0;
                    inc_sel  <= '0;
                end
                ST_LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state    <= ST_IDLE;
                        busy_led <= 1'b0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state <= ST_IDLE;
                    end else begin
                        best_cnt <= nb_cnt;
                        best_idx <= nb_idx;
                        best_tie <= nb_tie;
                        if (scan_idx == SCAN_LAST) begin
                            state      <= ST_RESULT;
                            result_vld <= 1'b1;
                            winner_idx <= nb_idx;
                            winner_cnt <= nb_cnt;
                            tie        <= nb_tie;
                        end else begin
                            scan_idx <= scan_idx + IW'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (!mode) begin
                        state      <= ST_IDLE;
                        result_vld <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef VOTE_AUDIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            total_votes <= '0;
        end else if (inc_en && (total_votes != 16'hFFFF)) begin
            total_votes <= total_votes + 16'd1;
        end
    end
`else
    assign total_votes = '0;
`endif

endmodule
